// File: rtl/instr_decode_stage_pkg.sv
// Shared types and constants for the instruction decode stage:
// ALU control codes, micro-op layout, field widths and FSM states.
package instr_decode_stage_pkg;

  localparam int OPCODE_W = 4;
  localparam int FIELD_W  = 5;
  localparam int INSTR_W  = OPCODE_W + FIELD_W;

  // Opcodes at or above this value have no ALU mapping
  localparam logic [OPCODE_W-1:0] ILLEGAL_OPC_MIN = 4'd10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLLC = 4'd5,
    ALU_SRLC = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_NEG  = 4'd9
  } alu_ctrl_t;

  typedef struct packed {
    alu_ctrl_t          op;
    logic [FIELD_W-1:0] field;
    logic               last;
    logic               illegal;
  } uop_t;

  localparam int UOP_W = $bits(uop_t);

  typedef enum logic {ST_IDLE, ST_EXPAND} dec_state_t;

  function automatic logic is_illegal(input logic [OPCODE_W-1:0] opc);
    return opc >= ILLEGAL_OPC_MIN;
  endfunction

endpackage

// File: rtl/decode_fifo2.sv
// Two-entry micro-op FIFO; head entry is always visible on head_data.
// Storage is cleared on reset so the head reads as zero while empty after reset.
module decode_fifo2
  import instr_decode_stage_pkg::*;
#(
  parameter int W = UOP_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: maps 9-bit instructions to ALU micro-ops via a 2-entry FIFO.
// Define DECODE_SUB_EXPAND_EN to split Sub into a Neg/Add micro-op pair.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter bit ILLEGAL_PASS = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output alu_ctrl_t          out_op,
  output logic [FIELD_W-1:0] out_field,
  output logic               out_last,
  output logic               out_illegal,
  output logic               err_sticky
);

`ifdef DECODE_SUB_EXPAND_EN
  localparam bit SubExpand = 1'b1;
`else
  localparam bit SubExpand = 1'b0;
`endif

  dec_state_t         state_q, state_d;
  logic [FIELD_W-1:0] pend_field_q, pend_field_d;
  logic               err_q, err_d;

  logic [OPCODE_W-1:0] opc;
  logic [FIELD_W-1:0]  fld;
  logic                accept, push, pop, full, empty;
  uop_t                push_uop, head_uop;
  logic [UOP_W-1:0]    push_bits, head_bits;

  assign opc       = in_instr[INSTR_W-1:FIELD_W];
  assign fld       = in_instr[FIELD_W-1:0];
  assign in_ready  = (state_q == ST_IDLE) && !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push_bits = push_uop;
  assign head_uop  = uop_t'(head_bits);

  always_comb begin
    state_d      = state_q;
    pend_field_d = pend_field_q;
    err_d        = err_q;
    push         = 1'b0;
    push_uop     = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_illegal(opc)) begin
            err_d    = 1'b1;
            push     = ILLEGAL_PASS;
            push_uop = '{op: ALU_ADD, field: fld, last: 1'b1, illegal: 1'b1};
          end else if (SubExpand && (alu_ctrl_t'(opc) == ALU_SUB)) begin
            push         = 1'b1;
            push_uop     = '{op: ALU_NEG, field: fld, last: 1'b0, illegal: 1'b0};
            pend_field_d = fld;
            state_d      = ST_EXPAND;
          end else begin
            push     = 1'b1;
            push_uop = '{op: alu_ctrl_t'(opc), field: fld, last: 1'b1, illegal: 1'b0};
          end
        end
      end
      // Second half of an expanded Sub waits for a free FIFO slot
      ST_EXPAND: begin
        if (!full) begin
          push     = 1'b1;
          push_uop = '{op: ALU_ADD, field: pend_field_q, last: 1'b1, illegal: 1'b0};
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_field_q <= pend_field_d;
  end

  decode_fifo2 #(.W(UOP_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_bits),
    .pop       (pop),
    .head_data (head_bits),
    .full      (full),
    .empty     (empty)
  );

  assign out_op      = head_uop.op;
  assign out_field   = head_uop.field;
  assign out_last    = head_uop.last;
  assign out_illegal = head_uop.illegal;
  assign err_sticky  = err_q;

endmodule
